// File: rtl/reg32_bank_ctrl_if.sv
// Bus bundle for reg32_bank_ctrl: per-requester write requests with one-hot
// grant, bank-clear handshake and the combinational read port.
interface reg32_bank_ctrl_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned NREG = 4
);
  localparam int unsigned AW = $clog2(NREG);

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] wr_addr;
  logic [NREQ*32-1:0] wr_data;
  logic [NREQ-1:0]    gnt;
  logic               clr_start;
  logic               clr_busy;
  logic [AW-1:0]      rd_addr;
  logic [31:0]        rd_data;

  modport master (
    output req, wr_addr, wr_data, clr_start, rd_addr,
    input  gnt, clr_busy, rd_data
  );

  modport slave (
    input  req, wr_addr, wr_data, clr_start, rd_addr,
    output gnt, clr_busy, rd_data
  );
endinterface

// File: rtl/reg32_bank_ctrl.sv
// Round-robin write arbiter in front of a bank of 32-bit registers, with a
// sequenced bank-wide clear and a combinational read port.
module reg32_bank_ctrl #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned NREG = 4
) (
  input  logic             clk,
  input  logic             R,
  reg32_bank_ctrl_if.slave bus
);
  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACK   = 2'd1,
    S_CLEAR = 2'd2
  } state_e;

  state_e          r_state, w_state_nxt;
  logic [31:0]     r_regs [NREG];
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_pend, w_pend_nxt;
  logic [IW-1:0]   r_last, w_last_nxt;
  logic [AW-1:0]   r_idx, w_idx_nxt;

  logic            w_we;
  logic [AW-1:0]   w_waddr;
  logic [31:0]     w_wdata;
  logic            w_found;
  logic [IW-1:0]   w_win;
  logic [IW-1:0]   w_cand;
  logic [AW-1:0]   w_addr_a [NREQ];
  logic [31:0]     w_data_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_addr_a[g] = bus.wr_addr[g*AW +: AW];
    assign w_data_a[g] = bus.wr_data[g*32 +: 32];
  end

  // Round-robin search beginning just after the last winner
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_cand = IW'((32'(r_last) + 32'(k)) % NREQ);
      if (!w_found && bus.req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = '0;
    w_busy_nxt  = 1'b0;
    w_pend_nxt  = r_pend | bus.clr_start;
    w_last_nxt  = r_last;
    w_idx_nxt   = r_idx;
    w_we        = 1'b0;
    w_waddr     = '0;
    w_wdata     = '0;
    case (r_state)
      S_IDLE: begin
        // A pending or same-cycle clear request beats any write request
        if (r_pend || bus.clr_start) begin
          w_state_nxt = S_CLEAR;
          w_pend_nxt  = 1'b0;
          w_idx_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end else if (w_found) begin
          w_we             = 1'b1;
          w_waddr          = w_addr_a[w_win];
          w_wdata          = w_data_a[w_win];
          w_gnt_nxt[w_win] = 1'b1;
          w_last_nxt       = w_win;
          w_state_nxt      = S_ACK;
        end
      end
      S_ACK: begin
        w_state_nxt = S_IDLE;
      end
      S_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_idx;
        w_wdata = '0;
        if (r_idx == AW'(NREG - 1)) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_idx_nxt  = r_idx + 1'b1;
          w_busy_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
      r_pend  <= 1'b0;
      r_last  <= IW'(NREQ - 1);
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_busy  <= w_busy_nxt;
      r_pend  <= w_pend_nxt;
      r_last  <= w_last_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_we) begin
      r_regs[w_waddr] <= w_wdata;
    end
  end

  assign bus.gnt      = r_gnt;
  assign bus.clr_busy = r_busy;
  assign bus.rd_data  = r_regs[bus.rd_addr];
endmodule

// File: tb/tb_reg32_bank_ctrl.sv
// Scoreboard bench for reg32_bank_ctrl: a transaction-level model predicts
// grants, clear activity and register contents; a negedge monitor compares.
module tb_reg32_bank_ctrl;
  localparam int unsigned NREQ = 4;
  localparam int unsigned NREG = 4;
  localparam int unsigned AW   = 2;

  logic clk = 1'b0;
  logic R;
  always #10 clk = ~clk;

  reg32_bank_ctrl_if #(.NREQ(NREQ), .NREG(NREG)) bus ();

  reg32_bank_ctrl #(.NREQ(NREQ), .NREG(NREG)) dut (
    .clk (clk),
    .R   (R),
    .bus (bus)
  );

  typedef struct {
    int              cyc;
    logic [NREQ-1:0] g;
  } exp_t;

  exp_t        q[$];
  int          gnt_log[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          busy_cnt = 0;
  int          mode     = 0;   // 0 hold req, 1 drop on ack, 2 random traffic
  int          prev_win = -1;

  logic [31:0] m_mem [NREG];
  int          m_last;
  bit          m_pend, m_ack, m_busy;
  int          m_clr_left;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NREG; i++) m_mem[i] = '0;
    m_last     = NREQ - 1;
    m_pend     = 1'b0;
    m_ack      = 1'b0;
    m_busy     = 1'b0;
    m_clr_left = 0;
    prev_win   = -1;
    q.delete();
  endfunction

  // One clock edge of the behavioural model; returns the granted requester or -1.
  function automatic int model_step();
    int              win;
    logic [NREQ-1:0] g;
    win = -1;
    g   = '0;
    if (!R) begin
      model_reset();
      return -1;
    end
    if (m_clr_left > 0) begin
      m_mem[NREG - m_clr_left] = '0;
      m_clr_left--;
      m_busy = (m_clr_left > 0);
      m_pend = m_pend | bus.clr_start;
    end else if (m_ack) begin
      m_ack  = 1'b0;
      m_pend = m_pend | bus.clr_start;
    end else if (m_pend || bus.clr_start) begin
      m_pend     = 1'b0;
      m_clr_left = NREG;
      m_busy     = 1'b1;
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_last + k) % NREQ;
        if (win < 0 && bus.req[c]) win = c;
      end
      if (win >= 0) begin
        m_mem[bus.wr_addr[win*AW +: AW]] = bus.wr_data[win*32 +: 32];
        m_last = win;
        m_ack  = 1'b1;
        g[win] = 1'b1;
        q.push_back('{cyc, g});
      end
    end
    return win;
  endfunction

  task automatic new_txn(input int i);
    bus.wr_addr[i*AW +: AW] = AW'($urandom_range(0, NREG - 1));
    bus.wr_data[i*32 +: 32] = $urandom;
    bus.req[i]              = 1'b1;
  endtask

  task automatic tick();
    int win;
    @(posedge clk);
    cyc++;
    win = model_step();
    #1;
    bus.clr_start = 1'b0;
    if (prev_win >= 0) begin
      if (mode == 1) bus.req[prev_win] = 1'b0;
      else if (mode == 2) begin
        if ($urandom_range(0, 1) == 0) bus.req[prev_win] = 1'b0;
        else new_txn(prev_win);
      end
    end
    prev_win = win;
    if (mode == 2) begin
      for (int i = 0; i < NREQ; i++)
        if (!bus.req[i] && $urandom_range(0, 2) == 0) new_txn(i);
      if ($urandom_range(0, 24) == 0) bus.clr_start = 1'b1;
      bus.rd_addr = AW'($urandom_range(0, NREG - 1));
    end
  endtask

  task automatic do_reset();
    R = 1'b0;
    model_reset();
    tick();
    R = 1'b1;
  endtask

  task automatic check_all_zero(input string name);
    for (int a = 0; a < NREG; a++) begin
      bus.rd_addr = AW'(a);
      #1;
      check(name, bus.rd_data, 32'h0);
    end
  endtask

  // Monitor: compares every cycle and consumes expected grants in order
  always @(negedge clk) begin
    exp_t e;
    check("clr_busy", 32'(bus.clr_busy), 32'(m_busy));
    if (bus.clr_busy) busy_cnt++;
    check("rd_data", bus.rd_data, m_mem[bus.rd_addr]);
    while (q.size() > 0 && q[0].cyc < cyc) begin
      n_tests++;
      n_fail++;
      $display("FAIL gnt_missing: got %b, expected %b (cycle %0d)", bus.gnt, q[0].g, q[0].cyc);
      void'(q.pop_front());
    end
    if (bus.gnt !== '0) begin
      if (q.size() == 0 || q[0].cyc != cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL gnt_unexpected: got %b, expected 0000 (cycle %0d)", bus.gnt, cyc);
      end else begin
        e = q.pop_front();
        check("gnt", 32'(bus.gnt), 32'(e.g));
      end
      for (int i = 0; i < NREQ; i++)
        if (bus.gnt[i]) gnt_log.push_back(i);
    end
  end

  initial begin
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};

    // Reset held with every input active
    R             = 1'b0;
    bus.req       = '1;
    bus.clr_start = 1'b1;
    bus.wr_addr   = 8'h1B;
    bus.wr_data   = {$urandom, $urandom, $urandom, $urandom};
    bus.rd_addr   = '0;
    model_reset();
    tick();
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b1;
    check("rst_gnt", 32'(bus.gnt), 32'h0);
    check("rst_busy", 32'(bus.clr_busy), 32'h0);
    check_all_zero("rst_rd");

    // Release: all requesters held high, expect 0,1,2,3,0
    bus.clr_start = 1'b0;
    R = 1'b1;
    gnt_log.delete();
    repeat (10) tick();
    check("order_len", 32'(gnt_log.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      check("order", 32'(gnt_log[i]), 32'(exp_order[i]));
    bus.req = '0;

    // Single write from requester 2
    do_reset();
    mode = 1;
    bus.wr_addr[2*AW +: AW] = 2'd1;
    bus.wr_data[2*32 +: 32] = 32'hEEEEEEEE;
    bus.req     = 4'b0100;
    bus.rd_addr = 2'd1;
    tick();
    @(negedge clk);
    check("single_gnt", 32'(bus.gnt), 32'h4);
    check("single_rd", bus.rd_data, 32'hEEEEEEEE);
    for (int a = 0; a < NREG; a++) begin
      if (a != 1) begin
        bus.rd_addr = AW'(a);
        #1;
        check("single_other", bus.rd_data, 32'h0);
      end
    end
    tick();

    // Fairness and same-address serialization with last=0
    bus.wr_addr[0 +: AW] = 2'd2;
    bus.wr_data[0 +: 32] = 32'h11111111;
    bus.req = 4'b0001;
    tick();
    tick();
    bus.wr_addr[1*AW +: AW] = 2'd0;
    bus.wr_data[1*32 +: 32] = 32'h0AB000A0;
    bus.wr_addr[3*AW +: AW] = 2'd0;
    bus.wr_data[3*32 +: 32] = 32'hEE0E5EEE;
    bus.req = 4'b1010;
    gnt_log.delete();
    repeat (4) tick();
    bus.rd_addr = 2'd0;
    #1;
    check("fair_len", 32'(gnt_log.size()), 32'd2);
    check("fair_first", 32'(gnt_log[0]), 32'd1);
    check("fair_second", 32'(gnt_log[1]), 32'd3);
    check("fair_reg0", bus.rd_data, 32'hEE0E5EEE);

    // Clear priority over a pending requester
    for (int i = 0; i < NREQ; i++) begin
      bus.wr_addr[i*AW +: AW] = AW'(i);
      bus.wr_data[i*32 +: 32] = $urandom | 32'h1;
    end
    bus.req = '1;
    repeat (8) tick();
    bus.wr_addr[0 +: AW] = 2'd3;
    bus.wr_data[0 +: 32] = 32'h12345678;
    bus.req       = 4'b0001;
    bus.clr_start = 1'b1;
    busy_cnt = 0;
    gnt_log.delete();
    repeat (5) tick();
    check_all_zero("clr_rd");
    tick();
    tick();
    check("clr_busy_len", 32'(busy_cnt), 32'd4);
    check("clr_then_gnt_len", 32'(gnt_log.size()), 32'd1);
    check("clr_then_gnt", 32'(gnt_log[0]), 32'd0);

    // Clear requested during ACK, then again during the sweep
    busy_cnt = 0;
    bus.wr_addr[2*AW +: AW] = 2'd2;
    bus.wr_data[2*32 +: 32] = 32'hCAFEF00D;
    bus.req = 4'b0100;
    tick();
    bus.clr_start = 1'b1;
    tick();
    tick();
    bus.clr_start = 1'b1;
    tick();
    repeat (9) tick();
    check("double_clr_busy", 32'(busy_cnt), 32'd8);

    // Reset in the second clear cycle
    bus.clr_start = 1'b1;
    tick();
    tick();
    R = 1'b0;
    model_reset();
    #1;
    check("midclr_busy", 32'(bus.clr_busy), 32'h0);
    check("midclr_gnt", 32'(bus.gnt), 32'h0);
    check_all_zero("midclr_rd");
    tick();
    R = 1'b1;
    bus.req = '1;
    gnt_log.delete();
    tick();
    tick();
    check("midclr_prio", 32'(gnt_log[0]), 32'd0);

    // Randomized traffic with occasional clears and resets
    mode = 2;
    repeat (800) begin
      tick();
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    mode    = 0;
    bus.req = '0;
    repeat (12) tick();
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL gnt_outstanding: got %0d unmatched, expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/reg32_bank_ctrl.md
# reg32_bank_ctrl

Controller that shares a bank of 32-bit registers among several write requesters and sequences a bank-wide clear. It sits in front of the 32-bit register storage. It arbitrates write requests round-robin, commits one word per grant, and acknowledges each grant with a one-cycle pulse. A combinational read port exposes any register.

## Interface
- NREQ, 4, number of write requesters (2..8)
- NREG, 4, number of 32-bit registers; power of two, ≥2
- AW, log2(NREG) = 2, register address width
- clk  in  1  rising-edge clock
- R  in  1  reset, asynchronous, active-low (R=0 resets)
- req  in  NREQ  per-requester write request, level
- wr_addr  in  NREQ*AW  requester i address in bits [i*AW +: AW]
- wr_data  in  NREQ*32  requester i data in bits [i*32 +: 32]
- gnt  out  NREQ  one-hot grant/ack pulse, registered
- clr_start  in  1  single-cycle pulse requesting a bank clear
- clr_busy  out  1  high while the clear sweep runs
- rd_addr  in  AW  read address
- rd_data  out  32  combinational read of register rd_addr

## Operation
- Storage: NREG × 32-bit registers.
- Control is a 3-state FSM: IDLE, ACK, CLEAR.
- clr_pend flag:
  - Set on any cycle with clr_start=1.
  - Cleared on entry to CLEAR.
  - A clear pulse arriving in ACK or CLEAR is therefore never lost.
- IDLE, decision order:
  - clr_pend=1 → go to CLEAR, clear index=0. Clear has priority over any req.
  - Otherwise, if any req bit is high, pick a winner round-robin, starting the search at last+1 (mod NREQ).
  - At the same edge: write wr_data[win] into reg[wr_addr[win]], set gnt[win]=1, set last=win, go to ACK.
  - No req → stay in IDLE; gnt=0.
- ACK: gnt holds the one-hot value for exactly this cycle; no arbitration and no write; next state is IDLE with gnt=0.
- Requester rule:
  - Hold req, wr_addr and wr_data stable until gnt[i] is sampled high.
  - On that same edge, deassert req or present a new transaction.
  - A requester that keeps req high is re-arbitrated normally in the following IDLE.
- CLEAR:
  - Writes 0 to reg[index], one register per cycle, index = 0..NREG-1.
  - clr_busy=1 throughout.
  - After writing NREG-1, go to IDLE.
  - req inputs are ignored in CLEAR (no grant).
- Round-robin pointer `last` is unchanged by CLEAR.
- rd_data = reg[rd_addr], combinational. A write is visible after the committing edge.
- Reset (R=0, any state, including mid-CLEAR or mid-ACK):
  - All registers 0; gnt=0; clr_busy=0; clr_pend=0.
  - State=IDLE; last=NREQ-1, so requester 0 has first priority.
  - Reset overrides clr_start.

## Timing
- Write latency: req seen in IDLE at edge N → reg updated and gnt high after edge N. rd_data reflects the new value in cycle N+1.
- Peak throughput: one write per 2 cycles, since IDLE and ACK alternate.
- Clear duration: clr_busy high for exactly NREG cycles.
  - clr_start sampled in IDLE at edge N → clr_busy high from edge N+1 through N+NREG.
  - If clr_start arrives in ACK, CLEAR begins one cycle later.
- Same-cycle clr_pend and req in IDLE: clear wins; pending reqs are granted after CLEAR ends.
- clr_start during CLEAR: sets clr_pend, so a second full sweep follows back-to-back after at most one IDLE cycle.
- Round-robin wrap: after last=NREQ-1 the search starts at requester 0.
- Only one register is written per cycle. Two requesters targeting the same address are serialized in grant order; the later grant's data remains.

## Test plan
- Reset: hold R=0 with req=4'b1111 and clr_start=1 → gnt=0, clr_busy=0, rd_data=0 for every address. Release R, all four req high → grant order 0,1,2,3,0, each gnt pulse one cycle and separated by one idle cycle.
- Single write: requester 2 writes addr 1 = 32'hEEEEEEEE → gnt=4'b0100 one cycle after req is sampled; rd_addr=1 reads 32'hEEEEEEEE in the following cycle; other registers stay 0.
- Fairness plus same address: requesters 1 and 3 both write addr 0 (32'h0AB000A0, 32'hEE0E5EEE) with last=0 → requester 1 granted first, then 3; reg0 ends at 32'hEE0E5EEE.
- Clear priority: load all regs with nonzero values; pulse clr_start while requester 0 is pending → clr_busy high for exactly 4 cycles, all regs read 0, then requester 0 granted.
- Clear during ACK: pulse clr_start in the ACK cycle → sweep starts on the following IDLE decision; no pulse lost.
- Reset mid-clear: assert R=0 during the second clear cycle → clr_busy drops immediately, all regs 0, FSM in IDLE, and requester 0 has priority after release.
